// File: rtl/whack_a_mole_pkg.sv
// rtl/whack_a_mole_pkg.sv - shared types and width helpers for the whack-a-mole blocks
package whack_a_mole_pkg;

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;

  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int LEVEL_W = width_for(7);

endpackage

// File: rtl/ms_prescaler.sv
// rtl/ms_prescaler.sv - millisecond prescaler with synchronous clear, emits ms_tick
module ms_prescaler
  import whack_a_mole_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic ms_tick
);

  localparam int CW = width_for(CLKS_PER_MS - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] count;

  assign ms_tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// rtl/mole_round_scheduler.sv - alternates UP/DOWN mole phases that shorten with level and combo
module mole_round_scheduler
  import whack_a_mole_pkg::*;
#(
  parameter int CLKS_PER_MS     = 50000,
  parameter int BASE_UP_MS      = 1000,
  parameter int BASE_DOWN_MS    = 500,
  parameter int STEP_MS         = 100,
  parameter int MIN_UP_MS       = 250,
  parameter int MIN_DOWN_MS     = 100,
  parameter int LEVEL_PERIOD_MS = 5000,
  parameter int MAX_LEVEL       = 7,
  parameter int COMBO_THRESHOLD = 10,
  parameter int COMBO_W         = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               game_in_progress,
  input  logic [COMBO_W-1:0]                 combo_count,
  input  logic                               full_clear_hit,
  output logic                               mole_clk,
  output logic                               round_start,
  output logic [width_for(MAX_LEVEL)-1:0]    level
);

  localparam int LW = width_for(MAX_LEVEL);
  localparam int PW = width_for(imax(imax(BASE_UP_MS, BASE_DOWN_MS), imax(MIN_UP_MS, MIN_DOWN_MS)));
  localparam int TW = width_for(LEVEL_PERIOD_MS - 1);

  state_e        state, state_next;
  logic          load;
  logic [PW-1:0] load_val;
  logic [PW-1:0] phase_cnt;
  logic          ms_tick;
  logic [LW-1:0] time_level;
  logic [TW-1:0] level_ms;
  logic          combo_bonus;
  logic [LW:0]   eff_sum;
  logic [LW-1:0] eff;
  int            up_full, down_full;
  logic [PW-1:0] up_ms, down_ms;

  ms_prescaler #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (load || !game_in_progress),
    .enable (state != IDLE),
    .ms_tick(ms_tick)
  );

  // Durations are worked out in 32-bit signed so a high level cannot wrap below the floor.
  always_comb begin
    combo_bonus = (combo_count >= COMBO_W'(COMBO_THRESHOLD));
    eff_sum     = {1'b0, time_level} + (LW+1)'(combo_bonus);
    eff         = (eff_sum > (LW+1)'(MAX_LEVEL)) ? LW'(MAX_LEVEL) : eff_sum[LW-1:0];
    up_full     = BASE_UP_MS - int'(eff) * STEP_MS;
    down_full   = BASE_DOWN_MS - int'(eff) * STEP_MS;
    if (up_full < MIN_UP_MS) up_full = MIN_UP_MS;
    if (down_full < MIN_DOWN_MS) down_full = MIN_DOWN_MS;
    up_ms       = PW'(up_full);
    down_ms     = PW'(down_full);
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = phase_cnt;
    case (state)
      IDLE: begin
        state_next = UP;
        load       = 1'b1;
        load_val   = up_ms;
      end
      UP: begin
        if (full_clear_hit || (ms_tick && phase_cnt == PW'(1))) begin
          state_next = DOWN;
          load       = 1'b1;
          load_val   = down_ms;
        end
      end
      DOWN: begin
        if (ms_tick && phase_cnt == PW'(1)) begin
          state_next = UP;
          load       = 1'b1;
          load_val   = up_ms;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!game_in_progress) begin
      state_next = IDLE;
      load       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mole_clk    <= 1'b0;
      round_start <= 1'b0;
      level       <= '0;
      phase_cnt   <= '0;
      time_level  <= '0;
      level_ms    <= '0;
    end else begin
      state       <= state_next;
      mole_clk    <= (state_next == UP);
      round_start <= (state_next == UP) && (state != UP);
      level       <= game_in_progress ? eff : '0;

      if (!game_in_progress) begin
        phase_cnt <= '0;
      end else if (load) begin
        phase_cnt <= load_val;
      end else if (ms_tick) begin
        phase_cnt <= phase_cnt - PW'(1);
      end

      // Game-time level only advances while a round is actually running.
      if (!game_in_progress) begin
        time_level <= '0;
        level_ms   <= '0;
      end else if (ms_tick) begin
        if (level_ms == TW'(LEVEL_PERIOD_MS - 1)) begin
          level_ms <= '0;
          if (time_level != LW'(MAX_LEVEL)) time_level <= time_level + LW'(1);
        end else begin
          level_ms <= level_ms + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb/tb_mole_round_scheduler.sv - self-checking bench for mole_round_scheduler
module tb_mole_round_scheduler;

  localparam int CLKS = 4, BU = 4, BD = 2, ST = 1, MU = 1, MD = 1;
  localparam int LP = 10, ML = 3, THR = 5, CW = 7;

  logic          clk = 1'b0;
  logic          rst, gip, fch;
  logic [CW-1:0] combo;
  logic          mole_clk, round_start;
  logic [1:0]    level;

  always #5 clk = ~clk;

  mole_round_scheduler #(
    .CLKS_PER_MS(CLKS), .BASE_UP_MS(BU), .BASE_DOWN_MS(BD), .STEP_MS(ST),
    .MIN_UP_MS(MU), .MIN_DOWN_MS(MD), .LEVEL_PERIOD_MS(LP), .MAX_LEVEL(ML),
    .COMBO_THRESHOLD(THR), .COMBO_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .game_in_progress(gip), .combo_count(combo),
    .full_clear_hit(fch), .mole_clk(mole_clk), .round_start(round_start), .level(level)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit check_en = 1'b0;

  // Reference: phase kind, cycles already spent in it, its length in cycles, in-game ms total.
  int m_phase = 0, m_elapsed = 0, m_len = 0, m_game_ms = 0;
  int e_mole = 0, e_rs = 0, e_level = 0;

  int tc[11] = '{1, 16, 17, 24, 25, 48, 49, 60, 61, 64, 65};
  int tm[11] = '{1,  1,  0,  0,  1,  0,  1,  1,  0,  0,  1};
  int tr[11] = '{1,  0,  0,  0,  1,  0,  1,  0,  0,  0,  1};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dur(input int base, input int mn, input int eff);
    int d;
    d = base - eff * ST;
    if (d < mn) d = mn;
    return d * CLKS;
  endfunction

  task automatic model_step();
    int tl, eff, nxt;
    bit tick;
    if (rst || !gip) begin
      m_phase = 0; m_elapsed = 0; m_len = 0; m_game_ms = 0;
      e_mole = 0; e_rs = 0; e_level = 0;
      return;
    end
    tl = m_game_ms / LP;
    if (tl > ML) tl = ML;
    eff = tl + ((combo >= THR) ? 1 : 0);
    if (eff > ML) eff = ML;
    tick = (m_phase != 0) && (m_elapsed % CLKS == CLKS - 1);
    nxt = m_phase;
    if (m_phase == 0) nxt = 1;
    else if (m_phase == 1 && (fch || m_elapsed + 1 == m_len)) nxt = 2;
    else if (m_phase == 2 && m_elapsed + 1 == m_len) nxt = 1;
    if (tick) m_game_ms++;
    e_rs = (nxt == 1 && m_phase != 1) ? 1 : 0;
    if (nxt != m_phase) begin
      m_len = (nxt == 1) ? dur(BU, MU, eff) : dur(BD, MD, eff);
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
    m_phase = nxt;
    e_mole  = (nxt == 1) ? 1 : 0;
    e_level = eff;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic measure_up(input string name, input int exp);
    int n = 0, g = 0;
    while (round_start !== 1'b1 && g < 200) begin step(); g++; end
    chk({name, "_wait"}, (g < 200) ? 1 : 0, 1);
    while (mole_clk === 1'b1 && n < 200) begin n++; step(); end
    chk(name, n, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; gip = 1'b0; fch = 1'b0; combo = '0;
    step(); step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("mole_clk", mole_clk, e_mole);
      chk("round_start", round_start, e_rs);
      chk("level", level, e_level);
    end
  end

  initial begin
    int n;
    rst = 1'b1; gip = 1'b0; fch = 1'b0; combo = '0;
    step();
    check_en = 1'b1;
    step(); step();
    chk("reset_mole", mole_clk, 0);
    chk("reset_rs", round_start, 0);
    chk("reset_level", level, 0);

    // Basic rounds and time-driven level step
    rst = 1'b0; gip = 1'b1; cyc = 0;
    repeat (66) begin
      step();
      for (int i = 0; i < 11; i++) begin
        if (tc[i] == cyc) begin
          chk($sformatf("basic_mole_c%0d", cyc), mole_clk, tm[i]);
          chk($sformatf("basic_rs_c%0d", cyc), round_start, tr[i]);
        end
      end
      if (cyc == 40) chk("basic_level_c40", level, 0);
      if (cyc == 45) chk("basic_level_c45", level, 1);
    end

    // Early clear; a clear during DOWN is ignored
    do_reset();
    gip = 1'b1; cyc = 0;
    repeat (16) begin
      step();
      fch = (cyc == 6 || cyc == 10);
      if (cyc == 7)  chk("clear_mole_c7", mole_clk, 0);
      if (cyc == 14) chk("clear_mole_c14", mole_clk, 0);
      if (cyc == 15) chk("clear_rs_c15", round_start, 1);
    end
    fch = 1'b0;

    // Combo bonus raises then lowers the level
    do_reset();
    gip = 1'b1; combo = 7'd5;
    measure_up("combo_up_bonus", 12);
    chk("combo_level_bonus", level, 1);
    combo = 7'd4;
    measure_up("combo_up_drop", 16);
    chk("combo_level_drop", level, 0);

    // Abort with game_in_progress, then with rst
    for (int k = 0; k < 2; k++) begin
      do_reset();
      gip = 1'b1;
      for (int g = 0; g < 400 && level !== 2'd2; g++) step();
      chk("abort_reach_l2", level, 2);
      n = 0;
      while (round_start !== 1'b1 && n < 100) begin step(); n++; end
      step(); step(); step();
      if (k == 0) gip = 1'b0; else rst = 1'b1;
      step();
      chk("abort_mole", mole_clk, 0);
      if (k == 0) step();
      chk("abort_level", level, 0);
      gip = 1'b1; rst = 1'b0;
      measure_up("abort_up_full", 16);
    end

    // Saturation at the top level with floors on both phases
    do_reset();
    gip = 1'b1; combo = 7'd9;
    repeat (600) step();
    chk("sat_level", level, 3);
    measure_up("sat_up", 4);
    n = 0;
    while (mole_clk === 1'b0 && n < 100) begin n++; step(); end
    chk("sat_down", n, 4);

    // Randomised traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      gip = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 19) == 0) combo = 7'($urandom_range(0, 9));
      fch = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
